serial_tx_arbiter: RTL
======================

// Module: serial_tx_arbiter
// PURPOSE
//  Shares one SerialTransciever transmit path among NUM_REQ requesters.
//  Picks a requester by round-robin and latches its word onto DataIn.
//  Sequences the Sample/StartTx handshake, then waits for TxDone.
//  Returns a per-requester Ack, or an Err pulse on timeout. Sits between client logic and the transceiver.
// PARAMETERS
//  NUM_REQ    4     number of requesters (2..8)
//  DATA_W     32    word width; matches transceiver DataIn
//  SAMPLE_CYC 2     Clk cycles Sample is held before StartTx
//  TIMEOUT    1023  max Clk cycles in START+WAIT before abort
// PORTS
//  Clk      in   1                 system clock, all logic on rising edge
//  Reset    in   1                 asynchronous, active-low (0 = reset)
//  Req      in   NUM_REQ           level request per requester
//  ReqData  in   NUM_REQ*DATA_W    word i at [i*DATA_W +: DATA_W]
//  Grant    out  NUM_REQ           one-hot; current owner, held for whole transfer
//  Ack      out  NUM_REQ           1-cycle pulse to owner on successful completion
//  Err      out  1                 1-cycle pulse on timeout abort
//  Busy     out  1                 high in any state other than IDLE
//  DataIn   out  DATA_W            word to transceiver, stable from LOAD until IDLE
//  Sample   out  1                 transceiver load strobe
//  StartTx  out  1                 transceiver start request
//  TxBusy   in   1                 from transceiver (ClkTx domain)
//  TxDone   in   1                 from transceiver (ClkTx domain)
// BEHAVIOUR
//  - Reset=0: all outputs go to 0 immediately; FSM enters IDLE; RR pointer=0; sync flops=0.
//    Applies mid-transfer too: no Ack or Err is issued for the aborted word.
//  - TxBusy and TxDone each pass through 2-flop synchronisers (tb_s, td_s).
//    done_edge = td_s & ~td_s_q.
//  - FSM states: IDLE, LOAD, START, WAIT, DONE.
//  - IDLE: if |Req, pick the first set Req at or after index ptr (with wrap).
//    Register Grant and DataIn=ReqData[win]; go to LOAD. Otherwise hold outputs at 0.
//  - LOAD: Sample=1 for exactly SAMPLE_CYC cycles, then go to START.
//  - START: Sample=0, StartTx=1. When tb_s=1, go to WAIT.
//  - WAIT: StartTx=0. On done_edge, go to DONE.
//    A TxDone level already high on entry is not treated as completion.
//  - DONE (1 cycle): Ack[win]=1, then Grant=0, ptr=(win+1)%NUM_REQ, go to IDLE.
//  - Timeout: counter clears on entry to START and counts each START/WAIT cycle.
//    At TIMEOUT: Err=1 for 1 cycle, Grant=0, StartTx=0, ptr advances, go to IDLE.
//  - Latency: Req seen at edge n -> Grant, DataIn and Sample high after edge n.
//    StartTx rises after edge n+SAMPLE_CYC.
//  - IDLE always spends at least 1 cycle between transfers, so Grant drops for >=1 cycle.
//  - Req dropping after grant is ignored: the transfer completes and Ack is still sent.
//  - Req staying high after Ack counts as a new request, arbitrated fairly behind the others.
//  - Simultaneous requests resolve strictly by round-robin from ptr; no requester is starved.
//  - Ack and Err are never asserted together; Grant stays one-hot or zero.
// TESTING
//  1. Reset low, Req=4'b1111 -> all outputs stay 0; Reset high -> Grant=0001 one cycle later, DataIn=ReqData[0].
//  2. Req=0010, ReqData[1]=32'h12345678 -> Sample high 2 cycles, StartTx held until TxBusy.
//     TxDone edge -> Ack=0010 for 1 cycle, Busy=0.
//  3. Req=1111 held for 4 transfers -> Grant order 0001,0010,0100,1000, then wraps to 0001.
//  4. TxBusy never asserted -> Err pulses exactly TIMEOUT cycles after entering START; no Ack; next grant goes to the next index.
//  5. Reset low during WAIT -> outputs 0 asynchronously, no Ack; after release, a pending Req restarts from index 0.
//  6. TxDone stuck high before START -> no Ack until TxDone falls and rises again.

Source files
------------

// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: round-robin owner of a single serial transceiver transmit path.
// Latches the winning requester's word, runs the Sample/StartTx handshake,
// waits for the TxDone edge, then returns an Ack or, after a bounded wait, an Err.
module serial_tx_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned SAMPLE_CYC = 2,
   parameter int unsigned TIMEOUT    = 1023
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic [NUM_REQ-1:0]        Req,
   input  logic [NUM_REQ*DATA_W-1:0] ReqData,
   output logic [NUM_REQ-1:0]        Grant,
   output logic [NUM_REQ-1:0]        Ack,
   output logic                      Err,
   output logic                      Busy,
   output logic [DATA_W-1:0]         DataIn,
   output logic                      Sample,
   output logic                      StartTx,
   input  logic                      TxBusy,
   input  logic                      TxDone
);

   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned SMP_W = $clog2(SAMPLE_CYC + 1);
   localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_START = 3'd2,
      ST_WAIT  = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   state_e               state_q, state_d;

   logic                 tb_m_q, tb_s_q;
   logic                 td_m_q, td_s_q, td_s_dly_q;
   logic                 done_edge_c;

   logic [PTR_W-1:0]     ptr_q, ptr_d;
   logic [PTR_W-1:0]     win_q, win_d;
   logic [PTR_W-1:0]     win_c, hi_idx_c, lo_idx_c, ptr_next_c;
   logic                 hi_vld_c;
   logic [DATA_W-1:0]    win_data_c;

   logic [SMP_W-1:0]     smp_cnt_q, smp_cnt_d;
   logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
   logic                 timeout_c;

   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [NUM_REQ-1:0]   ack_q, ack_d;
   logic                 err_q, err_d;
   logic                 busy_q, busy_d;
   logic [DATA_W-1:0]    data_q, data_d;
   logic                 sample_q, sample_d;
   logic                 start_q, start_d;

   // Two-flop synchronisers for the transceiver status, plus one extra stage for TxDone edge detect
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         tb_m_q     <= 1'b0;
         tb_s_q     <= 1'b0;
         td_m_q     <= 1'b0;
         td_s_q     <= 1'b0;
         td_s_dly_q <= 1'b0;
      end else begin
         tb_m_q     <= TxBusy;
         tb_s_q     <= tb_m_q;
         td_m_q     <= TxDone;
         td_s_q     <= td_m_q;
         td_s_dly_q <= td_s_q;
      end
   end

   assign done_edge_c = td_s_q & ~td_s_dly_q;
   assign timeout_c   = (tmo_cnt_q == TMO_W'(TIMEOUT - 1));
   assign ptr_next_c  = (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + PTR_W'(1);

   // Round-robin pick: lowest set request at or above ptr, else lowest set request overall
   always_comb begin
      hi_idx_c = '0;
      hi_vld_c = 1'b0;
      lo_idx_c = '0;
      for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
         if (Req[i]) begin
            lo_idx_c = PTR_W'(i);
            if (i >= int'(ptr_q)) begin
               hi_idx_c = PTR_W'(i);
               hi_vld_c = 1'b1;
            end
         end
      end
      win_c = hi_vld_c ? hi_idx_c : lo_idx_c;
   end

   // Word of the current arbitration winner
   always_comb begin
      win_data_c = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (win_c == PTR_W'(i)) begin
            win_data_c = ReqData[i*DATA_W +: DATA_W];
         end
      end
   end

   // State register
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; the timeout abort takes priority over handshake progress
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (|Req) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            if (smp_cnt_q == SMP_W'(SAMPLE_CYC - 1)) state_d = ST_START;
         end
         ST_START: begin
            if (timeout_c)   state_d = ST_IDLE;
            else if (tb_s_q) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (timeout_c)        state_d = ST_IDLE;
            else if (done_edge_c) state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output and datapath next values, decoded from the upcoming state so outputs stay registered
   always_comb begin
      grant_d   = grant_q;
      data_d    = data_q;
      win_d     = win_q;
      ptr_d     = ptr_q;
      smp_cnt_d = smp_cnt_q;
      tmo_cnt_d = tmo_cnt_q;
      ack_d     = '0;
      err_d     = 1'b0;
      sample_d  = (state_d == ST_LOAD);
      start_d   = (state_d == ST_START);
      busy_d    = (state_d != ST_IDLE);
      case (state_q)
         ST_IDLE: begin
            if (state_d == ST_LOAD) begin
               grant_d   = NUM_REQ'(1) << win_c;
               data_d    = win_data_c;
               win_d     = win_c;
               smp_cnt_d = '0;
            end
         end
         ST_LOAD: begin
            smp_cnt_d = smp_cnt_q + SMP_W'(1);
            tmo_cnt_d = '0;
         end
         ST_START, ST_WAIT: begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            if (timeout_c) begin
               err_d   = 1'b1;
               grant_d = '0;
               data_d  = '0;
               ptr_d   = ptr_next_c;
            end else if (state_d == ST_DONE) begin
               ack_d = grant_q;
            end
         end
         ST_DONE: begin
            grant_d = '0;
            data_d  = '0;
            ptr_d   = ptr_next_c;
         end
         default: begin
            grant_d = '0;
            data_d  = '0;
         end
      endcase
   end

   // Output and datapath registers
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         grant_q   <= '0;
         ack_q     <= '0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
         data_q    <= '0;
         sample_q  <= 1'b0;
         start_q   <= 1'b0;
         win_q     <= '0;
         ptr_q     <= '0;
         smp_cnt_q <= '0;
         tmo_cnt_q <= '0;
      end else begin
         grant_q   <= grant_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
         data_q    <= data_d;
         sample_q  <= sample_d;
         start_q   <= start_d;
         win_q     <= win_d;
         ptr_q     <= ptr_d;
         smp_cnt_q <= smp_cnt_d;
         tmo_cnt_q <= tmo_cnt_d;
      end
   end

   assign Grant   = grant_q;
   assign Ack     = ack_q;
   assign Err     = err_q;
   assign Busy    = busy_q;
   assign DataIn  = data_q;
   assign Sample  = sample_q;
   assign StartTx = start_q;

endmodule
